// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, frame width and opcode constants for the SPI slave.
package spi_pkg;
    localparam int ADDR_SIZE_DEF = 8;
    localparam int FRAME_W = ADDR_SIZE_DEF + 2;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: loads one read byte and shifts it out MSB first on a registered miso.
module spi_tx_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic         miso,
    output logic         done
);
    localparam int LW = $clog2(W);
    logic [W-1:0]  sr;
    logic [LW-1:0] left;
    logic          busy;
    // done blocks a second load until the frame is closed by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            sr   <= '0;
            left <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            miso <= 1'b0;
        end else if (load && !busy && !done) begin
            miso <= data[W-1];
            sr   <= data << 1;
            left <= LW'(W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (left == '0) begin
                miso <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                miso <= sr[W-1];
                sr   <= sr << 1;
                left <= left - 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: deserializes MOSI command frames for the RAM and serializes read data onto MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    localparam int FW = ADDR_SIZE + 2;
    localparam int CW = $clog2(FW + 1);
    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [FW-2:0] sh;
    logic          rd_addr_flag, take, last, load, tx_done;
    assign take = !ss_n && state != IDLE && cnt != CW'(FW);
    assign last = take && cnt == CW'(FW - 1);
    assign load = !ss_n && tx_valid && state == READ_DATA && cnt == CW'(FW);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (ss_n)                  nxt = IDLE;
        else if (state == IDLE)    nxt = CHK_CMD;
        else if (state == CHK_CMD) nxt = !mosi ? WRITE : rd_addr_flag ? READ_DATA : READ_ADD;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            sh           <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_n) begin
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + 1'b1;
                sh  <= {sh[FW-3:0], mosi};
            end
            if (last) begin
                rx_data  <= {sh, mosi};
                rx_valid <= 1'b1;
                rd_addr_flag <= state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : rd_addr_flag;
            end
        end
    end
    spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .clr  (ss_n),
        .load (load),
        .data (tx_data),
        .miso (miso),
        .done (tx_done)
    );
    logic unused_ok;
    assign unused_ok = tx_done;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven frame vectors plus hand sequences for abort and async reset.
module tb_spi_slave;
    import spi_pkg::*;
    logic       clk, rst, ss_n, mosi, miso, rx_valid, tx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;
    int checks = 0, failures = 0;

    spi_slave dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic [9:0] exp_rx;
        logic       exp_flag;
        logic       rd;
        logic [7:0] tx;
        int         dly;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t v[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        int pulses = 0;
        logic [7:0] got;
        logic miso_hi = 1'b0;
        ss_n = 1'b0;
        tick;
        for (int i = 9; i >= 0; i--) begin
            mosi = t.frame[i];
            tx_valid = !t.rd && i == 5;
            tick;
            pulses += int'(rx_valid);
            miso_hi |= miso;
        end
        tx_valid = 1'b0;
        chk("rx_valid_at_k10", rx_valid, 1'b1);
        chk("rx_data", rx_data, t.exp_rx);
        chk("rd_addr_flag", dut.rd_addr_flag, t.exp_flag);
        tick;
        pulses += int'(rx_valid);
        chk("rx_valid_pulses", pulses, 1);
        if (t.rd) begin
            for (int d = 0; d < t.dly; d++) begin
                tick;
                miso_hi |= miso;
            end
            chk("miso_before_tx_valid", miso_hi, 1'b0);
            tx_valid = 1'b1;
            tx_data = t.tx;
            tick;
            tx_valid = 1'b0;
            tx_data = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                got[b] = miso;
                if (b > 0) tick;
            end
            chk("miso_byte", got, t.exp_miso);
            tick;
            chk("miso_after_bit0", miso, 1'b0);
        end else begin
            tx_valid = 1'b1;
            tx_data = 8'hFF;
            tick;
            tx_valid = 1'b0;
            tick;
            miso_hi |= miso;
            chk("miso_quiet_write", miso_hi, 1'b0);
        end
        ss_n = 1'b1;
        tick;
        chk("state_idle_after_frame", dut.state, IDLE);
    endtask

    initial begin
        v[0] = '{10'b00_0010_1010, 10'h02A, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        v[1] = '{10'b01_1100_0011, 10'h1C3, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        v[2] = '{10'b10_0010_1010, 10'h22A, 1'b1, 1'b0, 8'h00, 0, 8'h00};
        v[3] = '{10'b11_0000_0000, 10'h300, 1'b0, 1'b1, 8'hC3, 0, 8'hC3};
        v[4] = '{10'b10_0101_0101, 10'h255, 1'b1, 1'b0, 8'h00, 0, 8'h00};
        v[5] = '{10'b00_0001_0001, 10'h011, 1'b1, 1'b0, 8'h00, 0, 8'h00};
        v[6] = '{10'b11_0000_0000, 10'h300, 1'b0, 1'b1, 8'h80, 3, 8'h80};
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick; tick;
        rst = 1'b0;
        chk("reset_rx_data", rx_data, 10'h000);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_miso", miso, 1'b0);
        chk("reset_flag", dut.rd_addr_flag, 1'b0);
        tick;
        for (int n = 0; n < 7; n++) run_vec(v[n]);

        // abort a READ_ADD frame after 6 bits
        begin
            logic [9:0] f = 10'b10_1111_0000;
            int pulses = 0;
            ss_n = 1'b0;
            tick;
            for (int i = 9; i >= 4; i--) begin
                mosi = f[i];
                tick;
                pulses += int'(rx_valid);
            end
            chk("abort_state_read_add", dut.state, READ_ADD);
            ss_n = 1'b1;
            tick;
            pulses += int'(rx_valid);
            chk("abort_no_rx_valid", pulses, 0);
            chk("abort_state_idle", dut.state, IDLE);
            chk("abort_flag_kept", dut.rd_addr_flag, 1'b0);
            chk("abort_rx_data_kept", rx_data, 10'h300);
            ss_n = 1'b0;
            tick;
            mosi = 1'b1;
            tick;
            chk("after_abort_read_add", dut.state, READ_ADD);
            ss_n = 1'b1;
            tick;
        end
        run_vec('{10'b10_0011_1100, 10'h23C, 1'b1, 1'b0, 8'h00, 0, 8'h00});

        // asynchronous reset between edges during bit 5 of a READ_DATA frame
        begin
            logic [9:0] f = 10'b11_1010_0101;
            ss_n = 1'b0;
            tick;
            for (int i = 9; i >= 5; i--) begin
                mosi = f[i];
                tick;
            end
            #2 rst = 1'b1;
            #1;
            chk("async_rst_rx_data", rx_data, 10'h000);
            chk("async_rst_rx_valid", rx_valid, 1'b0);
            chk("async_rst_miso", miso, 1'b0);
            chk("async_rst_flag", dut.rd_addr_flag, 1'b0);
            chk("async_rst_state", dut.state, IDLE);
            chk("async_rst_cnt", dut.cnt, 0);
            #1 rst = 1'b0;
            ss_n = 1'b1;
            tick;
        end
        run_vec('{10'b00_0101_1010, 10'h05A, 1'b0, 1'b0, 8'h00, 0, 8'h00});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
